// File: rtl/alu_reservation_station.sv
// ---------------------------------------------------------------------------
// alu_reservation_station
//   Reservation station sitting directly upstream of the ALU. Issued ALU ops
//   wait here until both source operands are valid. The CDB is snooped every
//   cycle to wake pending operands by ROB tag. At most one ready entry per
//   cycle (lowest index first) is dispatched into the ALU.
//
// Ports
//   clk_in, rst_in (async, active-low), rdy_in (global freeze when low)
//   _clear        flush all entries (mispredict)
//   _stall        blocks issue accept and dispatch; CDB snooping continues
//   _iss_*        issue request from the decoder (op, rob id, two operands
//                 each given either as a value or as a pending producer tag)
//   _rs_full      all entries occupied
//   _cdb_*        common data bus broadcast (tag + value)
//   _alu_full     ALU cannot take an op this cycle
//   _alu_*        registered dispatch port into the ALU
// ---------------------------------------------------------------------------
module alu_reservation_station #(
    parameter int DEPTH = 8,
    parameter int ROB_W = 5,
    parameter int OP_W  = 4
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             _clear,
    input  logic             _stall,
    input  logic             _iss_valid,
    input  logic [OP_W-1:0]  _iss_op,
    input  logic [ROB_W-1:0] _iss_rob_id,
    input  logic             _iss_qj_busy,
    input  logic [ROB_W-1:0] _iss_qj,
    input  logic [31:0]      _iss_vj,
    input  logic             _iss_qk_busy,
    input  logic [ROB_W-1:0] _iss_qk,
    input  logic [31:0]      _iss_vk,
    output logic             _rs_full,
    input  logic             _cdb_ready,
    input  logic [ROB_W-1:0] _cdb_rob_id,
    input  logic [31:0]      _cdb_value,
    input  logic             _alu_full,
    output logic             _alu_ready,
    output logic [OP_W-1:0]  _alu_op,
    output logic [ROB_W-1:0] _alu_rob_id,
    output logic [31:0]      _alu_vj,
    output logic [31:0]      _alu_vk
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0] valid;
    logic [DEPTH-1:0] qj_busy;
    logic [DEPTH-1:0] qk_busy;
    logic [OP_W-1:0]  op     [DEPTH];
    logic [ROB_W-1:0] rob_id [DEPTH];
    logic [ROB_W-1:0] qj     [DEPTH];
    logic [ROB_W-1:0] qk     [DEPTH];
    logic [31:0]      vj     [DEPTH];
    logic [31:0]      vk     [DEPTH];

    logic [DEPTH-1:0] ready;
    logic [IDX_W-1:0] free_idx;
    logic [IDX_W-1:0] disp_idx;
    logic             issue_go;
    logic             disp_go;
    logic             fwd_j;
    logic             fwd_k;

    // Readiness looks at registered state only, so a CDB wake-up this cycle
    // becomes dispatchable on the following edge.
    assign ready    = valid & ~qj_busy & ~qk_busy;
    assign _rs_full = &valid;
    assign issue_go = _iss_valid && !_rs_full && !_stall;
    assign disp_go  = !_stall && !_alu_full && (|ready);

    // A producer broadcasting in the same cycle as the issue would otherwise
    // be missed: the new entry is not yet valid for the snoop loop.
    assign fwd_j = _iss_qj_busy && _cdb_ready && (_cdb_rob_id == _iss_qj);
    assign fwd_k = _iss_qk_busy && _cdb_ready && (_cdb_rob_id == _iss_qk);

    // Lowest-index priority encoders for allocation and dispatch.
    always_comb begin
        free_idx = '0;
        disp_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid[i]) free_idx = IDX_W'(i);
            if (ready[i])  disp_idx = IDX_W'(i);
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            valid       <= '0;
            qj_busy     <= '0;
            qk_busy     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                op[i]     <= '0;
                rob_id[i] <= '0;
                qj[i]     <= '0;
                qk[i]     <= '0;
                vj[i]     <= '0;
                vk[i]     <= '0;
            end
            _alu_ready  <= 1'b0;
            _alu_op     <= '0;
            _alu_rob_id <= '0;
            _alu_vj     <= '0;
            _alu_vk     <= '0;
        end else if (rdy_in) begin
            if (_clear) begin
                valid      <= '0;
                _alu_ready <= 1'b0;
            end else begin
                // CDB wake-up of pending operands in occupied entries
                for (int i = 0; i < DEPTH; i++) begin
                    if (valid[i] && _cdb_ready) begin
                        if (qj_busy[i] && (qj[i] == _cdb_rob_id)) begin
                            vj[i]      <= _cdb_value;
                            qj_busy[i] <= 1'b0;
                        end
                        if (qk_busy[i] && (qk[i] == _cdb_rob_id)) begin
                            vk[i]      <= _cdb_value;
                            qk_busy[i] <= 1'b0;
                        end
                    end
                end

                // Dispatch: the dispatched entry is valid, the allocated one
                // is free, so the two never collide on the same index.
                if (disp_go) begin
                    _alu_ready        <= 1'b1;
                    _alu_op           <= op[disp_idx];
                    _alu_rob_id       <= rob_id[disp_idx];
                    _alu_vj           <= vj[disp_idx];
                    _alu_vk           <= vk[disp_idx];
                    valid[disp_idx]   <= 1'b0;
                end else begin
                    _alu_ready        <= 1'b0;
                end

                if (issue_go) begin
                    valid[free_idx]   <= 1'b1;
                    op[free_idx]      <= _iss_op;
                    rob_id[free_idx]  <= _iss_rob_id;
                    qj[free_idx]      <= _iss_qj;
                    qk[free_idx]      <= _iss_qk;
                    qj_busy[free_idx] <= _iss_qj_busy && !fwd_j;
                    qk_busy[free_idx] <= _iss_qk_busy && !fwd_k;
                    vj[free_idx]      <= fwd_j ? _cdb_value : _iss_vj;
                    vk[free_idx]      <= fwd_k ? _cdb_value : _iss_vk;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_reservation_station.sv
module tb_alu_reservation_station;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        _clear;
    logic        _stall;
    logic        _iss_valid;
    logic [3:0]  _iss_op;
    logic [4:0]  _iss_rob_id;
    logic        _iss_qj_busy;
    logic [4:0]  _iss_qj;
    logic [31:0] _iss_vj;
    logic        _iss_qk_busy;
    logic [4:0]  _iss_qk;
    logic [31:0] _iss_vk;
    logic        _rs_full;
    logic        _cdb_ready;
    logic [4:0]  _cdb_rob_id;
    logic [31:0] _cdb_value;
    logic        _alu_full;
    logic        _alu_ready;
    logic [3:0]  _alu_op;
    logic [4:0]  _alu_rob_id;
    logic [31:0] _alu_vj;
    logic [31:0] _alu_vk;

    typedef struct packed {
        logic [3:0]  op;
        logic [4:0]  rob;
        logic [31:0] vj;
        logic [31:0] vk;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   fails  = 0;

    alu_reservation_station #(.DEPTH(8), .ROB_W(5), .OP_W(4)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        ._clear(_clear), ._stall(_stall),
        ._iss_valid(_iss_valid), ._iss_op(_iss_op), ._iss_rob_id(_iss_rob_id),
        ._iss_qj_busy(_iss_qj_busy), ._iss_qj(_iss_qj), ._iss_vj(_iss_vj),
        ._iss_qk_busy(_iss_qk_busy), ._iss_qk(_iss_qk), ._iss_vk(_iss_vk),
        ._rs_full(_rs_full),
        ._cdb_ready(_cdb_ready), ._cdb_rob_id(_cdb_rob_id), ._cdb_value(_cdb_value),
        ._alu_full(_alu_full), ._alu_ready(_alu_ready), ._alu_op(_alu_op),
        ._alu_rob_id(_alu_rob_id), ._alu_vj(_alu_vj), ._alu_vk(_alu_vk)
    );

    always #5 clk_in = ~clk_in;

    // Scoreboard: every dispatch pulse must match the oldest expectation.
    always @(negedge clk_in) begin
        if (rst_in && _alu_ready) begin
            exp_t e;
            checks++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL sb_unexpected: dispatch rob=%0d op=%0d vj=%h vk=%h, required none",
                         _alu_rob_id, _alu_op, _alu_vj, _alu_vk);
            end else begin
                e = sb.pop_front();
                if ({_alu_op, _alu_rob_id, _alu_vj, _alu_vk} !== e) begin
                    fails++;
                    $display("FAIL sb_dispatch: got op=%0d rob=%0d vj=%h vk=%h, required op=%0d rob=%0d vj=%h vk=%h",
                             _alu_op, _alu_rob_id, _alu_vj, _alu_vk, e.op, e.rob, e.vj, e.vk);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic drive_issue(input logic [3:0] op, input logic [4:0] rob,
                               input logic qjb, input logic [4:0] qj, input logic [31:0] vj,
                               input logic qkb, input logic [4:0] qk, input logic [31:0] vk);
        _iss_valid   = 1'b1;
        _iss_op      = op;
        _iss_rob_id  = rob;
        _iss_qj_busy = qjb;
        _iss_qj      = qj;
        _iss_vj      = vj;
        _iss_qk_busy = qkb;
        _iss_qk      = qk;
        _iss_vk      = vk;
    endtask

    task automatic idle_issue();
        _iss_valid   = 1'b0;
        _iss_qj_busy = 1'b0;
        _iss_qk_busy = 1'b0;
    endtask

    task automatic push(input logic [3:0] op, input logic [4:0] rob,
                        input logic [31:0] vj, input logic [31:0] vk);
        exp_t e;
        e.op = op; e.rob = rob; e.vj = vj; e.vk = vk;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        rst_in = 1'b0; rdy_in = 1'b1; _clear = 1'b0; _stall = 1'b0;
        _cdb_ready = 1'b0; _cdb_rob_id = '0; _cdb_value = '0; _alu_full = 1'b0;
        _iss_op = '0; _iss_rob_id = '0; _iss_qj = '0; _iss_vj = '0; _iss_qk = '0; _iss_vk = '0;
        idle_issue();
        #12;
        checks++;
        if (_alu_ready !== 1'b0) begin fails++; $display("FAIL reset_alu_ready: got %b, required 0", _alu_ready); end
        checks++;
        if (_rs_full !== 1'b0) begin fails++; $display("FAIL reset_rs_full: got %b, required 0", _rs_full); end
        checks++;
        if ({_alu_op, _alu_rob_id, _alu_vj, _alu_vk} !== '0) begin
            fails++;
            $display("FAIL reset_alu_data: got op=%0d rob=%0d vj=%h vk=%h, required all 0",
                     _alu_op, _alu_rob_id, _alu_vj, _alu_vk);
        end
        rst_in = 1'b1;
        step();
    endtask

    task automatic test_basic();
        drive_issue(4'h1, 5'd3, 1'b0, 5'd0, 32'd5, 1'b0, 5'd0, 32'd7);
        push(4'h1, 5'd3, 32'd5, 32'd7);
        step();
        idle_issue();
        checks++;
        if (_alu_ready !== 1'b0) begin fails++; $display("FAIL basic_issue_edge: alu_ready got %b, required 0", _alu_ready); end
        step();
        checks++;
        if (_alu_ready !== 1'b1 || _alu_rob_id !== 5'd3) begin
            fails++;
            $display("FAIL basic_dispatch: alu_ready=%b rob=%0d, required 1 and 3", _alu_ready, _alu_rob_id);
        end
        step();
        checks++;
        if (_alu_ready !== 1'b0) begin fails++; $display("FAIL basic_pulse: alu_ready got %b, required 0", _alu_ready); end
    endtask

    task automatic test_reset_midrun();
        _alu_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_issue(4'h2, 5'(16 + i), 1'b0, 5'd0, 32'(i), 1'b0, 5'd0, 32'(i));
            step();
        end
        idle_issue();
        #2 rst_in = 1'b0;
        #1;
        checks++;
        if (_alu_ready !== 1'b0 || _rs_full !== 1'b0 || _alu_rob_id !== 5'd0) begin
            fails++;
            $display("FAIL midrun_reset: alu_ready=%b rs_full=%b rob=%0d, required 0 0 0",
                     _alu_ready, _rs_full, _alu_rob_id);
        end
        #3 rst_in = 1'b1;
        _alu_full = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (_alu_ready !== 1'b0) begin fails++; $display("FAIL midrun_no_dispatch: cycle %0d alu_ready=%b, required 0", i, _alu_ready); end
        end
    endtask

    task automatic test_wakeup();
        drive_issue(4'h3, 5'd4, 1'b1, 5'd2, 32'hDEAD, 1'b0, 5'd0, 32'd1);
        push(4'h3, 5'd4, 32'h10, 32'd1);
        step();
        idle_issue();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (_alu_ready !== 1'b0) begin fails++; $display("FAIL wake_wait: cycle %0d alu_ready=%b, required 0", i, _alu_ready); end
            step();
        end
        _cdb_ready = 1'b1; _cdb_rob_id = 5'd2; _cdb_value = 32'h10;
        step();
        _cdb_ready = 1'b0;
        checks++;
        if (_alu_ready !== 1'b0) begin fails++; $display("FAIL wake_edge: alu_ready=%b, required 0", _alu_ready); end
        step();
        checks++;
        if (_alu_ready !== 1'b1 || _alu_rob_id !== 5'd4 || _alu_vj !== 32'h10) begin
            fails++;
            $display("FAIL wake_dispatch: alu_ready=%b rob=%0d vj=%h, required 1 4 00000010", _alu_ready, _alu_rob_id, _alu_vj);
        end
        step();
    endtask

    task automatic test_issue_forward();
        drive_issue(4'h4, 5'd5, 1'b0, 5'd0, 32'd3, 1'b1, 5'd6, 32'hBAD);
        _cdb_ready = 1'b1; _cdb_rob_id = 5'd6; _cdb_value = 32'd9;
        push(4'h4, 5'd5, 32'd3, 32'd9);
        step();
        idle_issue();
        _cdb_ready = 1'b0;
        step();
        checks++;
        if (_alu_ready !== 1'b1 || _alu_vk !== 32'd9) begin
            fails++;
            $display("FAIL fwd_dispatch: alu_ready=%b vk=%h, required 1 00000009", _alu_ready, _alu_vk);
        end
        step();
    endtask

    task automatic test_fill();
        _alu_full = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive_issue(4'(i), 5'(8 + i), 1'b0, 5'd0, 32'(i * 3), 1'b0, 5'd0, 32'(i + 100));
            push(4'(i), 5'(8 + i), 32'(i * 3), 32'(i + 100));
            step();
            checks++;
            if (_rs_full !== (i == 7)) begin fails++; $display("FAIL fill_rs_full: after %0d issues got %b, required %b", i + 1, _rs_full, (i == 7)); end
        end
        drive_issue(4'hF, 5'd20, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        step();
        idle_issue();
        checks++;
        if (_rs_full !== 1'b1) begin fails++; $display("FAIL fill_ninth: rs_full got %b, required 1", _rs_full); end
        _alu_full = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            checks++;
            if (_alu_ready !== 1'b1 || _alu_rob_id !== 5'(8 + i)) begin
                fails++;
                $display("FAIL fill_drain: slot %0d alu_ready=%b rob=%0d, required 1 %0d", i, _alu_ready, _alu_rob_id, 8 + i);
            end
            if (i == 0) begin
                checks++;
                if (_rs_full !== 1'b0) begin fails++; $display("FAIL fill_rs_fall: got %b, required 0", _rs_full); end
            end
        end
        step();
        checks++;
        if (_alu_ready !== 1'b0) begin fails++; $display("FAIL fill_empty: alu_ready got %b, required 0", _alu_ready); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            drive_issue(4'(9 + i), 5'(24 + i), 1'b0, 5'd0, 32'(i + 1000), 1'b0, 5'd0, 32'(i + 2000));
            push(4'(9 + i), 5'(24 + i), 32'(i + 1000), 32'(i + 2000));
            step();
            if (i > 0) begin
                checks++;
                if (_alu_ready !== 1'b1 || _alu_rob_id !== 5'(23 + i)) begin
                    fails++;
                    $display("FAIL b2b_dispatch: step %0d alu_ready=%b rob=%0d, required 1 %0d", i, _alu_ready, _alu_rob_id, 23 + i);
                end
            end
        end
        idle_issue();
        step();
        checks++;
        if (_alu_ready !== 1'b1 || _alu_rob_id !== 5'd27) begin
            fails++;
            $display("FAIL b2b_last: alu_ready=%b rob=%0d, required 1 27", _alu_ready, _alu_rob_id);
        end
        step();
    endtask

    task automatic test_stall();
        _stall = 1'b1;
        drive_issue(4'h5, 5'd21, 1'b0, 5'd0, 32'd1, 1'b0, 5'd0, 32'd1);
        step();
        _stall = 1'b0;
        drive_issue(4'h6, 5'd22, 1'b1, 5'd1, 32'd0, 1'b0, 5'd0, 32'd77);
        push(4'h6, 5'd22, 32'h55, 32'd77);
        step();
        idle_issue();
        _stall = 1'b1;
        _cdb_ready = 1'b1; _cdb_rob_id = 5'd1; _cdb_value = 32'h55;
        step();
        _cdb_ready = 1'b0;
        step();
        checks++;
        if (_alu_ready !== 1'b0) begin fails++; $display("FAIL stall_hold: alu_ready=%b, required 0", _alu_ready); end
        _stall = 1'b0;
        step();
        checks++;
        if (_alu_ready !== 1'b1 || _alu_vj !== 32'h55) begin
            fails++;
            $display("FAIL stall_release: alu_ready=%b vj=%h, required 1 00000055", _alu_ready, _alu_vj);
        end
        step();
    endtask

    task automatic test_clear_freeze();
        _alu_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive_issue(4'h7, 5'(i), 1'b0, 5'd0, 32'(i), 1'b0, 5'd0, 32'(i));
            step();
        end
        rdy_in = 1'b0;
        drive_issue(4'h8, 5'd29, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (_rs_full !== 1'b0 || _alu_ready !== 1'b0) begin
                fails++;
                $display("FAIL freeze_issue: cycle %0d rs_full=%b alu_ready=%b, required 0 0", i, _rs_full, _alu_ready);
            end
        end
        idle_issue();
        _alu_full = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (_alu_ready !== 1'b0) begin fails++; $display("FAIL freeze_dispatch: cycle %0d alu_ready=%b, required 0", i, _alu_ready); end
        end
        rdy_in = 1'b1;
        _clear = 1'b1;
        drive_issue(4'h9, 5'd30, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        step();
        _clear = 1'b0;
        idle_issue();
        checks++;
        if (_alu_ready !== 1'b0 || _rs_full !== 1'b0) begin
            fails++;
            $display("FAIL clear_edge: alu_ready=%b rs_full=%b, required 0 0", _alu_ready, _rs_full);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (_alu_ready !== 1'b0) begin fails++; $display("FAIL clear_flushed: cycle %0d alu_ready=%b rob=%0d, required 0", i, _alu_ready, _alu_rob_id); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_reset_midrun();
        test_wakeup();
        test_issue_forward();
        test_fill();
        test_back_to_back();
        test_stall();
        test_clear_freeze();
        step();
        checks++;
        if (sb.size() != 0) begin fails++; $display("FAIL sb_leftover: %0d expected dispatches missing, required 0", sb.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
